// File: rtl/flag_event_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flag_pkg
//  Purpose  : Shared types and constants for the flag event queue slice.
//             flag_vec_t mirrors the producer's packed flag vector
//             ({fourth, third, second, first}, bit 0 = first).
//  Revision : 1.0 - initial release
// ============================================================================
package flag_pkg;

    localparam int FLAG_N = 4;

    typedef struct packed {
        logic fourth;
        logic third;
        logic second;
        logic first;
    } flag_vec_t;

    typedef logic [1:0] flag_id_t;

    localparam flag_id_t ID_FIRST  = 2'd0;
    localparam flag_id_t ID_SECOND = 2'd1;
    localparam flag_id_t ID_THIRD  = 2'd2;
    localparam flag_id_t ID_FOURTH = 2'd3;

    // Round-robin successor; wraps naturally in 2 bits.
    function automatic flag_id_t next_id(input flag_id_t id);
        return id + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flag_event_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : flag_event_queue_if
//  Purpose  : Valid/ready event channel from the flag event queue to its
//             consumer.
//  Ports    : evt_valid_o, evt_id_o, evt_cnt_o, evt_sat_o  (queue -> consumer)
//             evt_ready_i                                  (consumer -> queue)
//  Revision : 1.0 - initial release
// ============================================================================
interface flag_event_queue_if
    import flag_pkg::*;
#(
    parameter int CNT_W = 4
);
    logic             evt_valid_o;
    logic             evt_ready_i;
    flag_id_t         evt_id_o;
    logic [CNT_W-1:0] evt_cnt_o;
    logic             evt_sat_o;

    // Queue side
    modport master (
        output evt_valid_o,
        output evt_id_o,
        output evt_cnt_o,
        output evt_sat_o,
        input  evt_ready_i
    );

    // Consumer side
    modport slave (
        input  evt_valid_o,
        input  evt_id_o,
        input  evt_cnt_o,
        input  evt_sat_o,
        output evt_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/flag_event_queue_rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter4
//  Purpose  : Combinational 4-way round-robin arbiter. Search starts at ptr
//             and proceeds ptr+1, ptr+2, ... modulo 4.
//  Ports    : req[3:0]    request vector
//             ptr[1:0]    highest-priority index (held by the parent)
//             gnt_valid   at least one request present
//             gnt_id[1:0] granted index
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4
    import flag_pkg::*;
(
    input  logic [3:0] req,
    input  flag_id_t   ptr,
    output logic       gnt_valid,
    output flag_id_t   gnt_id
);

    // Rotate requests so the ptr position lands at bit 0; only seven bits
    // of the doubled vector can ever be selected.
    logic [6:0] w_dbl;
    logic [3:0] w_rot;
    flag_id_t   w_off;

    assign w_dbl = {req[2:0], req};
    assign w_rot = w_dbl[ptr +: 4];

    // Lowest set bit of the rotated vector is the nearest request to ptr.
    always_comb begin
        w_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k[1:0];
            end
        end
    end

    assign gnt_valid = |req;
    assign gnt_id    = ptr + w_off;

endmodule
`default_nettype wire

// File: rtl/flag_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : flag_event_queue
//  Purpose  : Detects rising edges on a 4-bit flag vector, coalesces repeated
//             edges into per-flag saturating counters and delivers one event
//             at a time, round-robin, on a valid/ready channel.
//  Ports    : clk, rst_n (async, active-low)
//             flags_i[3:0] packed flags, en_i edge enable, clear_i sync clear
//             pend_o[3:0]  pending status
//             evt          event channel (flag_event_queue_if.master)
//  Revision : 1.0 - initial release
// ============================================================================
module flag_event_queue
    import flag_pkg::*;
#(
    parameter int CNT_W = 4
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FLAG_N-1:0]         flags_i,
    input  logic                      en_i,
    input  logic                      clear_i,
    output logic [FLAG_N-1:0]         pend_o,
    flag_event_queue_if.master        evt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    flag_vec_t          r_flags_q;
    logic [FLAG_N-1:0]  r_pend;
    logic [CNT_W-1:0]   r_cnt [FLAG_N];
    logic [FLAG_N-1:0]  r_sat;
    flag_id_t           r_ptr;

    logic               r_valid;
    flag_id_t           r_id;
    logic [CNT_W-1:0]   r_ecnt;
    logic               r_esat;

    logic [FLAG_N-1:0]  w_edge;
    logic               w_free;
    logic               w_gnt_valid;
    flag_id_t           w_gnt_id;
    logic               w_grant;
    logic [FLAG_N-1:0]  w_win;

    assign w_edge  = en_i ? (flags_i & ~r_flags_q) : '0;
    assign w_free  = ~r_valid | evt.evt_ready_i;
    // clear_i suppresses the grant so the winner's state is wiped, not sent.
    assign w_grant = w_free & w_gnt_valid & ~clear_i;
    assign w_win   = w_grant ? (4'b0001 << w_gnt_id) : '0;

    rr_arbiter4 u_arb (
        .req       (r_pend),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    // Flags already high at reset release must not look like edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags_q <= flag_vec_t'(4'hF);
        end else begin
            r_flags_q <= flag_vec_t'(flags_i);
        end
    end

    // Per-flag pending state. A grant and an edge on the same flag in one
    // cycle hand the old count to the slot and restart the flag at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_sat  <= '0;
            for (int i = 0; i < FLAG_N; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (clear_i) begin
            r_pend <= '0;
            r_sat  <= '0;
            for (int i = 0; i < FLAG_N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FLAG_N; i++) begin
                if (w_win[i]) begin
                    r_pend[i] <= w_edge[i];
                    r_cnt[i]  <= w_edge[i] ? C_CNT_ONE : '0;
                    r_sat[i]  <= 1'b0;
                end else if (w_edge[i]) begin
                    if (!r_pend[i]) begin
                        r_pend[i] <= 1'b1;
                        r_cnt[i]  <= C_CNT_ONE;
                        r_sat[i]  <= 1'b0;
                    end else if (r_cnt[i] == C_CNT_MAX) begin
                        r_sat[i]  <= 1'b1;
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + C_CNT_ONE;
                    end
                end
            end
        end
    end

    // Output slot and round-robin pointer. clear_i leaves a held event alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_id    <= ID_FIRST;
            r_ecnt  <= '0;
            r_esat  <= 1'b0;
            r_ptr   <= ID_FIRST;
        end else begin
            if (w_free) begin
                r_valid <= w_grant;
                if (w_grant) begin
                    r_id   <= w_gnt_id;
                    r_ecnt <= r_cnt[w_gnt_id];
                    r_esat <= r_sat[w_gnt_id];
                end
            end
            if (w_grant) begin
                r_ptr <= next_id(w_gnt_id);
            end
        end
    end

    assign evt.evt_valid_o = r_valid;
    assign evt.evt_id_o    = r_id;
    assign evt.evt_cnt_o   = r_ecnt;
    assign evt.evt_sat_o   = r_esat;
    assign pend_o          = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_flag_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flag_event_queue
//  Purpose  : Self-checking bench for flag_event_queue: a table of directed
//             vectors, hand-written multi-cycle corner sequences and a
//             randomized run against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flag_event_queue;
    import flag_pkg::*;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] flags;
    logic       en;
    logic       clr;
    logic       rdy;
    logic [3:0] pend;

    flag_event_queue_if #(.CNT_W(CNT_W)) evt_if ();
    assign evt_if.evt_ready_i = rdy;

    flag_event_queue #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flags_i (flags),
        .en_i    (en),
        .clear_i (clr),
        .pend_o  (pend),
        .evt     (evt_if.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model (spec rules, plain ints) -------------
    logic [3:0] m_fq;
    logic [3:0] m_pend;
    int         m_cnt [4];
    int         m_sat [4];
    int         m_ptr;
    int         m_v, m_id, m_c, m_s;

    task automatic model_reset();
        m_fq = 4'hF; m_pend = 4'h0; m_ptr = 0;
        m_v = 0; m_id = 0; m_c = 0; m_s = 0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_sat[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] e;
        int win;
        int k;
        bit free;
        e    = en ? (flags & ~m_fq) : 4'h0;
        free = (m_v == 0) || rdy;
        win  = -1;
        if (!clr) begin
            for (int j = 0; j < 4; j++) begin
                k = (m_ptr + j) % 4;
                if (win < 0 && m_pend[k]) win = k;
            end
        end
        if (free) begin
            if (win >= 0) begin
                m_v = 1; m_id = win; m_c = m_cnt[win]; m_s = m_sat[win];
                m_ptr = (win + 1) % 4;
                m_pend[win] = 1'b0; m_cnt[win] = 0; m_sat[win] = 0;
            end else begin
                m_v = 0;
            end
        end
        if (clr) begin
            m_pend = 4'h0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0; m_sat[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (e[i]) begin
                    if (!m_pend[i]) begin
                        m_pend[i] = 1'b1; m_cnt[i] = 1; m_sat[i] = 0;
                    end else if (m_cnt[i] == CMAX) begin
                        m_sat[i] = 1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
        m_fq = flags;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("valid", int'(evt_if.evt_valid_o), m_v);
        if (m_v != 0) begin
            chk("id",  int'(evt_if.evt_id_o),  m_id);
            chk("cnt", int'(evt_if.evt_cnt_o), m_c);
            chk("sat", int'(evt_if.evt_sat_o), m_s);
        end
        chk("pend", int'(pend), int'(m_pend));
    endtask

    // One clock: model follows the posedge, outputs compared at the negedge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flags = 4'h0; en = 1'b1; clr = 1'b0; rdy = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic pulse(input int b);
        flags = 4'h0; flags[b] = 1'b1;
        cycle();
        flags = 4'h0;
        cycle();
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic       rst;
        logic [3:0] f;
        logic       e, c, r;
        logic       ev;
        logic [1:0] eid;
        logic [3:0] ecnt;
        logic       esat;
        logic [3:0] epend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rs, logic [3:0] f, logic r, logic ev,
                                logic [1:0] id, logic [3:0] cn, logic [3:0] pd);
        vec_t v;
        v.rst = rs; v.f = f; v.e = 1'b1; v.c = 1'b0; v.r = r;
        v.ev = ev; v.eid = id; v.ecnt = cn; v.esat = 1'b0; v.epend = pd;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; flags = 4'b0101; en = 1'b1; clr = 1'b0; rdy = 1'b0;
        model_reset();

        // Reset primes flags_q; later rising bit 2 -> one event, 2 cycles.
        tbl.push_back(mk(1, 4'b0101, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0101, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0101, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 4'b0100));
        tbl.push_back(mk(0, 4'b0100, 1, 1, 2, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 4'b0000));
        // Round-robin from ptr = 0, then wrap 0 -> 3.
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 1, 4'b1110));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 1, 4'b1110));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 1, 1, 4'b1100));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 2, 1, 4'b1000));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 3, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b1001, 0, 0, 0, 0, 4'b1001));
        tbl.push_back(mk(0, 4'b1001, 0, 1, 0, 1, 4'b1000));
        tbl.push_back(mk(0, 4'b1001, 1, 1, 3, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b1001, 1, 0, 0, 0, 4'b0000));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = ~tbl[i].rst; flags = tbl[i].f; en = tbl[i].e;
            clr = tbl[i].c; rdy = tbl[i].r;
            cycle();
            chk($sformatf("tbl%0d_valid", i), int'(evt_if.evt_valid_o), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_pend", i), int'(pend), int'(tbl[i].epend));
            if (tbl[i].ev || tbl[i].rst) begin
                chk($sformatf("tbl%0d_id", i),  int'(evt_if.evt_id_o),  int'(tbl[i].eid));
                chk($sformatf("tbl%0d_cnt", i), int'(evt_if.evt_cnt_o), int'(tbl[i].ecnt));
                chk($sformatf("tbl%0d_sat", i), int'(evt_if.evt_sat_o), int'(tbl[i].esat));
            end
        end

        // Coalescing and saturation: 20 edges on bit 1 behind a held event.
        do_reset();
        pulse(0);
        for (int i = 0; i < 20; i++) pulse(1);
        rdy = 1'b1;
        cycle();
        chk("sat_valid", int'(evt_if.evt_valid_o), 1);
        chk("sat_id",    int'(evt_if.evt_id_o),    1);
        chk("sat_cnt",   int'(evt_if.evt_cnt_o),   15);
        chk("sat_sat",   int'(evt_if.evt_sat_o),   1);
        cycle();
        chk("sat_drain", int'(evt_if.evt_valid_o), 0);
        rdy = 1'b0;

        // Grant and edge collide on flag 0.
        do_reset();
        pulse(3);
        for (int i = 0; i < 3; i++) pulse(0);
        chk("col_pend", int'(pend), 1);
        flags = 4'b0001; rdy = 1'b1;
        cycle();
        chk("col_id1",   int'(evt_if.evt_id_o),  0);
        chk("col_cnt1",  int'(evt_if.evt_cnt_o), 3);
        chk("col_pend1", int'(pend), 1);
        cycle();
        chk("col_valid2", int'(evt_if.evt_valid_o), 1);
        chk("col_cnt2",   int'(evt_if.evt_cnt_o),   1);
        rdy = 1'b0; flags = 4'h0;
        cycle();

        // Clear with three flags pending and an event held.
        do_reset();
        pulse(0);
        flags = 4'b1110;
        cycle();
        chk("clr_pend_pre", int'(pend), 14);
        flags = 4'h0; clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr_pend",  int'(pend), 0);
        chk("clr_held",  int'(evt_if.evt_valid_o), 1);
        chk("clr_held_id", int'(evt_if.evt_id_o), 0);
        rdy = 1'b1;
        cycle();
        chk("clr_drain", int'(evt_if.evt_valid_o), 0);
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            flags = (i % 2 == 0) ? 4'hF : 4'h0;
            cycle();
            chk("en0_pend", int'(pend), 0);
        end
        en = 1'b1; flags = 4'h0; rdy = 1'b0;
        cycle();

        // Backpressure stability, then asynchronous reset mid-hold.
        do_reset();
        pulse(2);
        for (int i = 0; i < 10; i++) begin
            flags = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            cycle();
            chk("bp_valid", int'(evt_if.evt_valid_o), 1);
            chk("bp_id",    int'(evt_if.evt_id_o),    2);
            chk("bp_cnt",   int'(evt_if.evt_cnt_o),   1);
            chk("bp_sat",   int'(evt_if.evt_sat_o),   0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(evt_if.evt_valid_o), 0);
        chk("arst_pend",  int'(pend), 0);
        model_reset();
        cycle();
        rst_n = 1'b1; flags = 4'h0;
        cycle();

        // Randomized run: busy consumer, then a mostly-stalled consumer.
        for (int i = 0; i < 700; i++) begin
            flags = 4'($urandom);
            en    = ($urandom % 10) != 0;
            clr   = ($urandom % 25) == 0;
            rdy   = (i < 350) ? (($urandom % 3) != 0) : (($urandom % 5) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
